inv_shiftrows_stage: RTL and testbench

Registered InvShiftRows pipeline stage of the AES decryption round datapath. It sits directly upstream of the inverse SubBytes stage and feeds that stage's 128-bit state input. It applies the InvShiftRows byte permutation, carries a round tag and a last-round flag alongside the state, and decouples producer from consumer with a valid/ready handshake. A 2-entry skid buffer gives full throughput with registered ready.

---
 rtl/inv_shiftrows_stage.sv | 150 +++++++++++++++
 tb/tb_inv_shiftrows_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shiftrows_stage.sv
// ============================================================================
// Module   : inv_shiftrows_stage
// Purpose  : Registered AES InvShiftRows stage with 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_shiftrows_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last
);

  // State encoding is {main_v, skid_v}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_HALF  = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [127:0]     main_state_q, main_state_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic             main_last_q, main_last_d;
  logic [127:0]     skid_state_q, skid_state_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_last_q, skid_last_d;

  logic [127:0]     perm_state;
  logic             accept;
  logic             emit;
  logic             main_load_in;
  logic             main_load_skid;
  logic             skid_load;

  // Row r rotated right by r: output (r,c) takes input (r,(c-r) mod 4).
  for (genvar k = 0; k < 16; k++) begin : g_perm
    localparam int ROW = k % 4;
    localparam int COL = k / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign perm_state[127-8*k -: 8] = in_state[127-8*SRC -: 8];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_HALF;
        ST_HALF: begin
          if (emit && !accept)      state_d = ST_EMPTY;
          else if (!emit && accept) state_d = ST_FULL;
        end
        ST_FULL:  if (emit) state_d = ST_HALF;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs and load enables, all decoded from the registered state.
  always_comb begin
    in_ready       = ~state_q[0];
    out_valid      = state_q[1];
    accept         = in_valid & ~state_q[0];
    emit           = state_q[1] & out_ready;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: main_load_in = accept;
        ST_HALF: begin
          if (emit) main_load_in = accept;
          else      skid_load    = accept;
        end
        ST_FULL:  main_load_skid = emit;
        default:  ;
      endcase
    end
  end

  always_comb begin
    main_state_d = main_state_q;
    main_tag_d   = main_tag_q;
    main_last_d  = main_last_q;
    skid_state_d = skid_state_q;
    skid_tag_d   = skid_tag_q;
    skid_last_d  = skid_last_q;
    if (main_load_in) begin
      main_state_d = perm_state;
      main_tag_d   = in_tag;
      main_last_d  = in_last;
    end else if (main_load_skid) begin
      main_state_d = skid_state_q;
      main_tag_d   = skid_tag_q;
      main_last_d  = skid_last_q;
    end
    if (skid_load) begin
      skid_state_d = perm_state;
      skid_tag_d   = in_tag;
      skid_last_d  = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_state_q <= '0;
      main_tag_q   <= '0;
      main_last_q  <= 1'b0;
      skid_state_q <= '0;
      skid_tag_q   <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      main_state_q <= main_state_d;
      main_tag_q   <= main_tag_d;
      main_last_q  <= main_last_d;
      skid_state_q <= skid_state_d;
      skid_tag_q   <= skid_tag_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign out_state = main_state_q;
  assign out_tag   = main_tag_q;
  assign out_last  = main_last_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_shiftrows_stage.sv
// ============================================================================
// Module   : tb_inv_shiftrows_stage
// Purpose  : Scoreboard bench for inv_shiftrows_stage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inv_shiftrows_stage;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [TAG_W-1:0] in_tag;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_state;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;

  inv_shiftrows_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_tag    (in_tag),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_tag   (out_tag),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0]     st;
    logic [TAG_W-1:0] tag;
    logic             last;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference InvShiftRows from the explicit byte-source table.
  function automatic logic [127:0] model(input logic [127:0] s);
    int           src[16];
    logic [127:0] r;
    src = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    r   = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[127-8*src[k] -: 8];
    return r;
  endfunction

  function automatic logic [127:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i * 17 + 5);
    return {16{b}} ^ 128'h0123456789abcdeffedcba9876543210;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; record the expected output if it will be accepted.
  task automatic step(input logic v, input logic [127:0] s, input logic [TAG_W-1:0] t,
                      input logic l, input logic ordy, output logic acc);
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    in_state  = s;
    in_tag    = t;
    in_last   = l;
    out_ready = ordy;
    #1;
    acc = v && in_ready && !flush;
    if (acc) begin
      e.st   = model(s);
      e.tag  = t;
      e.last = l;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops on every emit and checks stability under backpressure.
  initial begin : monitor
    ent_t e;
    ent_t held;
    logic stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 160'(out_valid), 160'(1'b1));
          chk("hold_data", 160'({out_state, out_tag, out_last}), 160'(held));
        end
        if (out_valid && out_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out: got tag %0d state %h expected no output", out_tag, out_state);
          end else begin
            e = sb.pop_front();
            if ({out_state, out_tag, out_last} !== e) begin
              n_bad++;
              $display("FAIL sb_out: got %h/%0d/%0b expected %h/%0d/%0b",
                       out_state, out_tag, out_last, e.st, e.tag, e.last);
            end
          end
        end
        stall = out_valid && !out_ready && !flush;
        held  = {out_state, out_tag, out_last};
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_state = '0;
    in_tag = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_in_ready",  160'(in_ready),  160'(1'b1));
    chk("rst_out_state", 160'(out_state), 160'(0));
    chk("rst_out_tag",   160'(out_tag),   160'(0));
    chk("rst_out_last",  160'(out_last),  160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer permutation
    step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd3, 1'b0, 1'b1, acc);
    chk("kat_accept", 160'(acc), 160'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("kat_valid", 160'(out_valid), 160'(1'b1));
    chk("kat_state", 160'(out_state), 160'(128'h000d0a0704010e0b0805020f0c090603));
    chk("kat_tag",   160'(out_tag),   160'(4'd3));
    chk("kat_last",  160'(out_last),  160'(1'b0));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Streaming: 16 back-to-back entries
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pat(i), TAG_W'(i), (i == 15), 1'b1, acc);
      chk("stream_accept", 160'(acc), 160'(1'b1));
      if (i > 0) chk("stream_valid", 160'(out_valid), 160'(1'b1));
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("stream_tail_valid", 160'(out_valid), 160'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("stream_drain_valid", 160'(out_valid), 160'(1'b0));
    chk("stream_drain_sb", 160'(sb.size()), 160'(0));

    // Backpressure: only two entries fit
    step(1'b1, pat(101), 4'd1, 1'b0, 1'b0, acc);
    chk("bp_acc1", 160'(acc), 160'(1'b1));
    step(1'b1, pat(102), 4'd2, 1'b0, 1'b0, acc);
    chk("bp_acc2", 160'(acc), 160'(1'b1));
    step(1'b1, pat(103), 4'd3, 1'b1, 1'b0, acc);
    chk("bp_full_a", 160'(acc), 160'(1'b0));
    step(1'b1, pat(103), 4'd3, 1'b1, 1'b0, acc);
    chk("bp_full_b", 160'(acc), 160'(1'b0));
    step(1'b1, pat(103), 4'd3, 1'b1, 1'b1, acc);
    chk("bp_full_release", 160'(acc), 160'(1'b0));
    step(1'b1, pat(103), 4'd3, 1'b1, 1'b1, acc);
    chk("bp_acc3", 160'(acc), 160'(1'b1));
    chk("bp_emit2_valid", 160'(out_valid), 160'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("bp_emit3_valid", 160'(out_valid), 160'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("bp_done_valid", 160'(out_valid), 160'(1'b0));
    chk("bp_done_sb", 160'(sb.size()), 160'(0));

    // Accept and emit together in HALF
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat(200 + i), TAG_W'(i + 5), i[0], 1'b1, acc);
      chk("half_accept", 160'(acc), 160'(1'b1));
      if (i > 0) chk("half_valid", 160'(out_valid), 160'(1'b1));
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("half_drain_sb", 160'(sb.size()), 160'(0));

    // Flush while FULL, with a new input offered in the flush cycle
    step(1'b1, pat(300), 4'd7, 1'b0, 1'b0, acc);
    step(1'b1, pat(301), 4'd8, 1'b1, 1'b0, acc);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_state = pat(302); in_tag = 4'd9; out_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 160'(out_valid), 160'(1'b0));
    chk("flush_in_ready",  160'(in_ready),  160'(1'b1));
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Asynchronous reset while FULL
    step(1'b1, pat(400), 4'd10, 1'b0, 1'b0, acc);
    step(1'b1, pat(401), 4'd11, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("ar_pre_full", 160'(in_ready), 160'(1'b0));
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_out_valid", 160'(out_valid), 160'(1'b0));
    chk("ar_in_ready",  160'(in_ready),  160'(1'b1));
    chk("ar_out_state", 160'(out_state), 160'(0));
    chk("ar_out_tag",   160'(out_tag),   160'(0));
    chk("ar_out_last",  160'(out_last),  160'(0));
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b1, pat(500), 4'd12, 1'b1, 1'b1, acc);
    chk("ar_post_accept", 160'(acc), 160'(1'b1));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("ar_post_valid", 160'(out_valid), 160'(1'b1));
    chk("ar_post_state", 160'(out_state), 160'(model(pat(500))));
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("ar_post_sb", 160'(sb.size()), 160'(0));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
